// File: rtl/pmod_adc_pkg.sv
// Shared types and helpers for the Pmod_ADC (MCP3008-style) responder model.
// Holds the transfer state encoding, command field widths and the differential subtract.
package pmod_adc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_START,
        CMD,
        SAMPLE,
        MSB,
        LSB,
        ZERO
    } adc_state_t;

    localparam int ADC_CMD_BITS = 4;
    localparam int ADC_CH_BITS  = 3;

    // Operand width of adc_diff; result widths up to this value are supported.
    localparam int ADC_DIFF_W = 16;

    // Pseudo-differential result: plus - minus, clamped at zero instead of wrapping.
    function automatic logic [ADC_DIFF_W-1:0] adc_diff(
        input logic [ADC_DIFF_W-1:0] plus,
        input logic [ADC_DIFF_W-1:0] minus
    );
        return (plus > minus) ? (plus - minus) : '0;
    endfunction

endpackage

// File: rtl/adc_sync_edge.sv
// Multi-flop synchronizer for one asynchronous SPI line, with one-clk rise/fall strobes.
// Strobes are held off until the chain has refilled after reset, so a line that differs
// from RESET_VAL at reset release does not look like an edge.
module adc_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic [SYNC_STAGES:0]   warm_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
            warm_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
            prev_q <= sync_q[SYNC_STAGES-1];
            warm_q <= {warm_q[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = warm_q[SYNC_STAGES] & level & ~prev_q;
    assign fall  = warm_q[SYNC_STAGES] & ~level & prev_q;

endmodule

// File: rtl/mcp3008_responder.sv
// Responder-side model of the 8-channel 10-bit SPI ADC: oversamples AD_CLK/CS/DIN,
// decodes start/SGL/D2..D0 and shifts back a null bit plus the selected channel code.
module mcp3008_responder
    import pmod_adc_pkg::*;
#(
    parameter int NUM_CH      = 8,
    parameter int RES         = 10,
    parameter int SYNC_STAGES = 2,
    parameter int LSB_TRAIL   = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ad_clk,
    input  logic                    cs,
    input  logic                    din,
    input  logic [NUM_CH*RES-1:0]   ch_data,
    output logic                    dout,
    output logic                    dout_oe,
    output logic                    conv_done,
    output logic [ADC_CH_BITS-1:0]  conv_ch,
    output logic                    conv_sgl,
    output logic [RES-1:0]          conv_code
);

    localparam int CNT_W = ($clog2(RES) > 2) ? $clog2(RES) : 2;

    logic sclk_unused;
    logic clk_rise;
    logic clk_fall;
    logic cs_s;
    logic cs_rise;
    logic cs_fall;
    logic din_s;

    logic [SYNC_STAGES-1:0] din_q;

    adc_state_t              state;
    logic [CNT_W-1:0]        bit_cnt;
    logic [ADC_CMD_BITS-1:0] cmd;
    logic [RES-1:0]          hold;
    logic                    sample_rise;

    logic [ADC_CMD_BITS-1:0] next_cmd;
    logic [ADC_CH_BITS-1:0]  plus_ch;
    logic [ADC_CH_BITS-1:0]  minus_ch;
    logic [RES-1:0]          plus_val;
    logic [RES-1:0]          minus_val;
    logic [RES-1:0]          result;

    adc_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b0)
    ) u_sync_sclk (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (ad_clk),
        .level (sclk_unused),
        .rise  (clk_rise),
        .fall  (clk_fall)
    );

    adc_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b1)
    ) u_sync_cs (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (cs),
        .level (cs_s),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    // Same depth as the ad_clk chain so din_s lines up with the rise strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            din_q <= '0;
        end else begin
            din_q <= {din_q[SYNC_STAGES-2:0], din};
        end
    end

    assign din_s = din_q[SYNC_STAGES-1];

    // Operands are evaluated against the command as it will look after the D0 shift.
    assign next_cmd  = {cmd[ADC_CMD_BITS-2:0], din_s};
    assign plus_ch   = next_cmd[ADC_CH_BITS-1:0];
    assign minus_ch  = {plus_ch[ADC_CH_BITS-1:1], ~plus_ch[0]};
    assign plus_val  = ch_data[int'(plus_ch) * RES +: RES];
    assign minus_val = ch_data[int'(minus_ch) * RES +: RES];

    always_comb begin
        result = plus_val;
        if (!next_cmd[ADC_CMD_BITS-1]) begin
            result = RES'(adc_diff(ADC_DIFF_W'(plus_val), ADC_DIFF_W'(minus_val)));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            cmd         <= '0;
            hold        <= '0;
            sample_rise <= 1'b0;
            dout        <= 1'b0;
            dout_oe     <= 1'b0;
            conv_done   <= 1'b0;
            conv_ch     <= '0;
            conv_sgl    <= 1'b0;
            conv_code   <= '0;
        end else begin
            conv_done <= 1'b0;
            if (cs_rise || cs_s) begin
                // Deselect aborts anything in flight; last conversion results stay put.
                state   <= IDLE;
                dout    <= 1'b0;
                dout_oe <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        dout_oe <= 1'b0;
                        if (cs_fall) begin
                            state       <= WAIT_START;
                            bit_cnt     <= '0;
                            cmd         <= '0;
                            sample_rise <= 1'b0;
                        end
                    end
                    WAIT_START: begin
                        if (clk_rise && din_s) begin
                            state   <= CMD;
                            bit_cnt <= '0;
                        end
                    end
                    CMD: begin
                        if (clk_rise) begin
                            cmd     <= next_cmd;
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt == CNT_W'(ADC_CMD_BITS - 1)) begin
                                hold        <= result;
                                sample_rise <= 1'b0;
                                state       <= SAMPLE;
                            end
                        end
                    end
                    SAMPLE: begin
                        if (clk_rise) begin
                            sample_rise <= 1'b1;
                        end else if (clk_fall && sample_rise) begin
                            dout_oe <= 1'b1;
                            dout    <= 1'b0;
                            bit_cnt <= CNT_W'(RES - 1);
                            state   <= MSB;
                        end
                    end
                    MSB: begin
                        if (clk_fall) begin
                            dout <= hold[bit_cnt];
                            if (bit_cnt == '0) begin
                                conv_done <= 1'b1;
                                conv_ch   <= cmd[ADC_CH_BITS-1:0];
                                conv_sgl  <= cmd[ADC_CMD_BITS-1];
                                conv_code <= hold;
                                if (LSB_TRAIL != 0) begin
                                    bit_cnt <= CNT_W'(1);
                                    state   <= LSB;
                                end else begin
                                    state <= ZERO;
                                end
                            end else begin
                                bit_cnt <= bit_cnt - 1'b1;
                            end
                        end
                    end
                    LSB: begin
                        if (clk_fall) begin
                            dout <= hold[bit_cnt];
                            if (bit_cnt == CNT_W'(RES - 1)) begin
                                state <= ZERO;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                    end
                    ZERO: begin
                        if (clk_fall) begin
                            dout <= 1'b0;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mcp3008_responder.sv
// Directed bench for mcp3008_responder: single-ended, differential, leading zeros,
// hold-register isolation, mid-word deselect and mid-word reset.
module tb_mcp3008_responder;

    localparam int RES = 10;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           ad_clk = 1'b0;
    logic           cs = 1'b1;
    logic           din = 1'b0;
    logic [8*RES-1:0] ch_data = '0;
    logic           dout;
    logic           dout_oe;
    logic           conv_done;
    logic [2:0]     conv_ch;
    logic           conv_sgl;
    logic [RES-1:0] conv_code;

    int   n_checks = 0;
    int   n_pass = 0;
    int   done_cnt = 0;
    logic rx_bits [0:31];
    logic oe_bits [0:31];

    mcp3008_responder #(
        .NUM_CH      (8),
        .RES         (RES),
        .SYNC_STAGES (2),
        .LSB_TRAIL   (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ad_clk    (ad_clk),
        .cs        (cs),
        .din       (din),
        .ch_data   (ch_data),
        .dout      (dout),
        .dout_oe   (dout_oe),
        .conv_done (conv_done),
        .conv_ch   (conv_ch),
        .conv_sgl  (conv_sgl),
        .conv_code (conv_code)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (conv_done === 1'b1) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One AD_CLK period at clk/16: dout is sampled at the end of the low phase,
    // i.e. it shows what the previous falling edge launched.
    task automatic spi_bit(input logic b, output logic q, output logic oe);
        din = b;
        repeat (8) @(negedge clk);
        q  = dout;
        oe = dout_oe;
        ad_clk = 1'b1;
        repeat (8) @(negedge clk);
        ad_clk = 1'b0;
    endtask

    // Cycle 0 carries the start bit, 1..4 carry SGL,D2,D1,D0; later cycles clock zeros.
    task automatic xfer(input logic [3:0] cmd, input int lead, input int ncycles, input logic poke_ch5);
        logic q, oe, b;
        cs = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < lead; i++) spi_bit(1'b0, q, oe);
        for (int j = 0; j < ncycles; j++) begin
            if (poke_ch5 && j == 5) ch_data[5*RES +: RES] = 10'h001;
            b = 1'b0;
            if (j == 0) b = 1'b1;
            else if (j <= 4) b = cmd[4-j];
            spi_bit(b, q, oe);
            rx_bits[j] = q;
            oe_bits[j] = oe;
        end
    endtask

    task automatic cs_high();
        ad_clk = 1'b0;
        cs = 1'b1;
        repeat (16) @(negedge clk);
    endtask

    function automatic logic [9:0] msb_word();
        logic [9:0] w;
        for (int i = 0; i < 10; i++) w[9-i] = rx_bits[7+i];
        return w;
    endfunction

    function automatic logic [8:0] lsb_word();
        logic [8:0] w;
        for (int i = 0; i < 9; i++) w[i] = rx_bits[17+i];
        return w;
    endfunction

    initial begin
        int   d0;
        logic any_oe;

        ch_data[5*RES +: RES] = 10'h2A7;
        ch_data[2*RES +: RES] = 10'd300;
        ch_data[3*RES +: RES] = 10'd100;
        repeat (4) @(negedge clk);
        check("rst_dout", 32'(dout), 32'h0);
        check("rst_oe", 32'(dout_oe), 32'h0);
        check("rst_done", 32'(conv_done), 32'h0);
        check("rst_ch", 32'(conv_ch), 32'h0);
        check("rst_sgl", 32'(conv_sgl), 32'h0);
        check("rst_code", 32'(conv_code), 32'h0);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);

        // Single-ended ch5 with the LSB-first trailer
        d0 = done_cnt;
        xfer(4'b1101, 0, 29, 1'b0);
        cs_high();
        check("se_oe_before_null", 32'(oe_bits[5]), 32'h0);
        check("se_oe_at_null", 32'(oe_bits[6]), 32'h1);
        check("se_null_bit", 32'(rx_bits[6]), 32'h0);
        check("se_msb_word", 32'(msb_word()), 32'h2A7);
        check("se_lsb_trail", 32'(lsb_word()), 32'h153);
        check("se_zero_tail", 32'({rx_bits[26], rx_bits[27], rx_bits[28]}), 32'h0);
        check("se_done_pulses", 32'(done_cnt - d0), 32'h1);
        check("se_conv_ch", 32'(conv_ch), 32'h5);
        check("se_conv_sgl", 32'(conv_sgl), 32'h1);
        check("se_conv_code", 32'(conv_code), 32'h2A7);

        // Differential ch2-ch3 = 200, then ch3-ch2 saturates at 0
        xfer(4'b0010, 0, 29, 1'b0);
        cs_high();
        check("diff_msb_word", 32'(msb_word()), 32'd200);
        check("diff_conv_code", 32'(conv_code), 32'd200);
        check("diff_conv_ch", 32'(conv_ch), 32'h2);
        check("diff_conv_sgl", 32'(conv_sgl), 32'h0);
        xfer(4'b0011, 0, 29, 1'b0);
        cs_high();
        check("sat_msb_word", 32'(msb_word()), 32'h0);
        check("sat_conv_code", 32'(conv_code), 32'h0);
        check("sat_conv_ch", 32'(conv_ch), 32'h3);

        // Leading zeros, and ch5 changed after the D0 rise
        d0 = done_cnt;
        xfer(4'b1101, 3, 29, 1'b1);
        cs_high();
        check("lead_msb_word", 32'(msb_word()), 32'h2A7);
        check("lead_conv_code", 32'(conv_code), 32'h2A7);
        check("lead_done_pulses", 32'(done_cnt - d0), 32'h1);
        ch_data[5*RES +: RES] = 10'h2A7;

        // Deselect right after B6 is on the line
        d0 = done_cnt;
        xfer(4'b1010, 0, 10, 1'b0);
        repeat (4) @(negedge clk);
        check("abort_oe_before", 32'(dout_oe), 32'h1);
        cs = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("abort_oe_latency", 32'(dout_oe), 32'h1);
        @(negedge clk);
        check("abort_oe_off", 32'(dout_oe), 32'h0);
        check("abort_dout_off", 32'(dout), 32'h0);
        repeat (16) @(negedge clk);
        check("abort_no_done", 32'(done_cnt - d0), 32'h0);
        check("abort_code_kept", 32'(conv_code), 32'h2A7);
        d0 = done_cnt;
        xfer(4'b1010, 0, 29, 1'b0);
        cs_high();
        check("after_abort_word", 32'(msb_word()), 32'd300);
        check("after_abort_code", 32'(conv_code), 32'd300);
        check("after_abort_done", 32'(done_cnt - d0), 32'h1);

        // Reset in the middle of the MSB phase (B7 = 1 is being driven)
        xfer(4'b1101, 0, 9, 1'b0);
        repeat (3) @(negedge clk);
        check("mid_oe_before_rst", 32'(dout_oe), 32'h1);
        check("mid_dout_before_rst", 32'(dout), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_dout", 32'(dout), 32'h0);
        check("arst_oe", 32'(dout_oe), 32'h0);
        check("arst_code", 32'(conv_code), 32'h0);
        check("arst_ch", 32'(conv_ch), 32'h0);
        check("arst_sgl", 32'(conv_sgl), 32'h0);
        repeat (3) @(negedge clk);
        ad_clk = 1'b0;
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        d0 = done_cnt;
        xfer(4'b1101, 0, 29, 1'b0);
        any_oe = 1'b0;
        for (int j = 0; j < 29; j++) any_oe = any_oe | oe_bits[j];
        check("stale_cs_no_oe", 32'(any_oe), 32'h0);
        check("stale_cs_no_done", 32'(done_cnt - d0), 32'h0);
        check("stale_cs_code", 32'(conv_code), 32'h0);
        cs_high();
        d0 = done_cnt;
        xfer(4'b1101, 0, 29, 1'b0);
        cs_high();
        check("post_rst_word", 32'(msb_word()), 32'h2A7);
        check("post_rst_code", 32'(conv_code), 32'h2A7);
        check("post_rst_done", 32'(done_cnt - d0), 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
